ifetch: RTL and testbench

- Instruction fetch stage of the RV32 core; sits directly downstream of the PC register.
- Takes the current PC and issues one 32-bit request at a time to instruction memory over a valid/ready interface.
- Holds the returned word in an output register with a valid/ready handshake to decode.
- Pulses `pc_en` so next-PC logic advances the PC only when decode accepts an instruction; supports pipeline flush and misaligned-PC faults.

---
 rtl/ifetch_pkg.sv | 20 ++
 rtl/ifetch_if.sv | 31 +++
 rtl/ifetch_sva.sv | 45 ++++
 rtl/ifetch.sv | 115 +++++++++++
 tb/tb_ifetch.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_pkg.sv
// Shared core definitions for the fetch stage: datapath width, reset vector,
// fetch FSM state encoding and a small address helper.
package ifetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    FULL = 3'd3,
    DROP = 3'd4
  } fetch_state_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_if.sv
// Fetch-stage bus: instruction-memory request/response channel plus the
// instruction handshake towards decode.
interface ifetch_if;
  import ifetch_pkg::*;

  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            inst_valid;
  logic [XLEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;
  logic            inst_fault;
  logic            inst_ready;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output inst_valid, inst_data, inst_pc, inst_fault,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  inst_valid, inst_data, inst_pc, inst_fault,
    output inst_ready
  );

endinterface

// File: rtl/ifetch_sva.sv
// Protocol checker bound into every ifetch instance: request stability,
// pc_en qualification and responses only while one is owed.
module ifetch_sva
  import ifetch_pkg::*;
(
  input logic            clk,
  input logic            rst,
  input logic            flush,
  input logic            pc_en,
  input logic            req_valid,
  input logic            req_ready,
  input logic            rsp_valid,
  input logic            inst_valid,
  input logic            inst_ready,
  input logic [XLEN-1:0] req_addr,
  input logic [2:0]      state
);

  localparam logic [2:0] ST_WAIT = WAIT;
  localparam logic [2:0] ST_DROP = DROP;

  a_req_stable: assert property (@(posedge clk) disable iff (!rst)
    req_valid && !req_ready && !flush |=> req_valid && $stable(req_addr));

  a_pc_en_qual: assert property (@(posedge clk) disable iff (!rst)
    pc_en |-> inst_valid && inst_ready && !flush);

  a_rsp_owed: assert property (@(posedge clk) disable iff (!rst)
    rsp_valid |-> (state == ST_WAIT || state == ST_DROP));

endmodule

bind ifetch ifetch_sva u_sva (
  .clk       (clk),
  .rst       (rst),
  .flush     (flush),
  .pc_en     (pc_en),
  .req_valid (req_valid),
  .req_ready (req_ready),
  .rsp_valid (rsp_valid),
  .inst_valid(inst_valid_reg),
  .inst_ready(inst_ready),
  .req_addr  (req_addr_reg),
  .state     (state_reg)
);

// File: rtl/ifetch.sv
// RV32 instruction fetch: one outstanding imem request at a time, registered
// instruction slot towards decode, pc_en pulse when decode takes a word.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [XLEN-1:0] START_ADDR = RESET_VECTOR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  input  logic            flush,
  output logic            pc_en,
  ifetch_if.master        bus
);

  localparam logic [2:0] ST_IDLE = IDLE;
  localparam logic [2:0] ST_REQ  = REQ;
  localparam logic [2:0] ST_WAIT = WAIT;
  localparam logic [2:0] ST_FULL = FULL;
  localparam logic [2:0] ST_DROP = DROP;

  logic [2:0]      state_reg, state_next;
  logic [XLEN-1:0] req_addr_reg;
  logic [XLEN-1:0] inst_pc_reg;
  logic [XLEN-1:0] inst_data_reg;
  logic            inst_valid_reg;
  logic            inst_fault_reg;

  logic capture, load_rsp, load_fault;
  logic req_valid, req_ready, rsp_valid, inst_ready, misaligned;

  assign req_ready  = bus.imem_req_ready;
  assign rsp_valid  = bus.imem_rsp_valid;
  assign inst_ready = bus.inst_ready;
  assign misaligned = (pc_in[1:0] != 2'b00);

  assign req_valid = (state_reg == ST_REQ);
  assign pc_en     = (state_reg == ST_FULL) && inst_ready && !flush;

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    load_rsp   = 1'b0;
    load_fault = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        capture = 1'b1;
        if (misaligned && !flush) begin
          state_next = ST_FULL;
          load_fault = 1'b1;
        end else begin
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        // A request accepted in the flush cycle still owes us a response.
        if (flush)          state_next = req_ready ? ST_DROP : ST_IDLE;
        else if (req_ready) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (rsp_valid) begin
          if (flush) begin
            state_next = ST_IDLE;
          end else begin
            state_next = ST_FULL;
            load_rsp   = 1'b1;
          end
        end else if (flush) begin
          state_next = ST_DROP;
        end
      end
      ST_FULL: begin
        if (flush || inst_ready) state_next = ST_IDLE;
      end
      ST_DROP: begin
        // Only one response can be in flight, so leave as soon as it lands.
        if (rsp_valid) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      req_addr_reg   <= START_ADDR;
      inst_pc_reg    <= START_ADDR;
      inst_data_reg  <= '0;
      inst_fault_reg <= 1'b0;
      inst_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      inst_valid_reg <= (state_next == ST_FULL);
      if (capture) begin
        req_addr_reg <= word_align(pc_in);
        inst_pc_reg  <= pc_in;
      end
      if (load_fault) begin
        inst_data_reg  <= '0;
        inst_fault_reg <= 1'b1;
      end else if (load_rsp) begin
        inst_data_reg  <= bus.imem_rsp_data;
        inst_fault_reg <= 1'b0;
      end
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = req_addr_reg;
  assign bus.inst_valid     = inst_valid_reg;
  assign bus.inst_data      = inst_data_reg;
  assign bus.inst_pc        = inst_pc_reg;
  assign bus.inst_fault     = inst_fault_reg;

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed cycle table, reset-in-flight sequence and a
// randomized run against a transaction-level PC/memory model.
module tb_ifetch;
  import ifetch_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic        flush;
  logic        pc_en;

  ifetch_if bus ();

  ifetch #(.START_ADDR(32'h0000_0000)) dut (
    .clk  (clk),
    .rst  (rst),
    .pc_in(pc_in),
    .flush(flush),
    .pc_en(pc_en),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        fl;
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        ir;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic        chk;
    logic [31:0] e_data;
    logic [31:0] e_pc;
    logic        e_fault;
    logic        e_pc_en;
  } vec_t;

  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(
    input logic [31:0] pc, input logic fl, input logic rdy, input logic rv,
    input logic [31:0] rd, input logic ir, input logic e_rv, input logic [31:0] e_addr,
    input logic e_iv, input logic chk, input logic [31:0] e_data,
    input logic [31:0] e_pc, input logic e_fault, input logic e_pc_en);
    vec_t v;
    v.pc = pc; v.fl = fl; v.rdy = rdy; v.rv = rv; v.rd = rd; v.ir = ir;
    v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv; v.chk = chk;
    v.e_data = e_data; v.e_pc = e_pc; v.e_fault = e_fault; v.e_pc_en = e_pc_en;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called right after a rising edge; drives the row, samples mid-cycle,
  // then advances to just after the next rising edge.
  task automatic run_row(input vec_t v, input string tag);
    pc_in              = v.pc;
    flush              = v.fl;
    bus.imem_req_ready = v.rdy;
    bus.imem_rsp_valid = v.rv;
    bus.imem_rsp_data  = v.rd;
    bus.inst_ready     = v.ir;
    #4;
    check({tag, " req_valid"},  {31'd0, bus.imem_req_valid}, {31'd0, v.e_rv});
    check({tag, " req_addr"},   bus.imem_req_addr, v.e_addr);
    check({tag, " inst_valid"}, {31'd0, bus.inst_valid}, {31'd0, v.e_iv});
    check({tag, " pc_en"},      {31'd0, pc_en}, {31'd0, v.e_pc_en});
    if (v.chk) begin
      check({tag, " inst_data"},  bus.inst_data, v.e_data);
      check({tag, " inst_pc"},    bus.inst_pc, v.e_pc);
      check({tag, " inst_fault"}, {31'd0, bus.inst_fault}, {31'd0, v.e_fault});
    end
    $display("%s: pc_in=%h req_v=%0b addr=%h inst_v=%0b data=%h ipc=%h flt=%0b pc_en=%0b",
             tag, pc_in, bus.imem_req_valid, bus.imem_req_addr, bus.inst_valid,
             bus.inst_data, bus.inst_pc, bus.inst_fault, pc_en);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic idle_inputs();
    pc_in              = 32'h0;
    flush              = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.inst_ready     = 1'b0;
  endtask

  vec_t tbl[$];

  logic [31:0] pc_model, out_addr, tgt;
  logic        outstanding, rsp_now, accept, exp_fault;
  int          cnt, delivered;

  initial begin
    rst = 1'b0;
    idle_inputs();

    // pc, fl, rdy, rv, rd, ir | e_rv, e_addr, e_iv, chk, e_data, e_pc, e_fault, e_pc_en
    tbl.push_back(mk(32'h0, 0, 1, 0, 32'h0,  1, 0, 32'h0, 0, 1, 32'h0,  32'h0, 0, 0));
    tbl.push_back(mk(32'h0, 0, 1, 0, 32'h0,  1, 1, 32'h0, 0, 0, 32'h0,  32'h0, 0, 0));
    tbl.push_back(mk(32'h0, 0, 1, 1, 32'h13, 1, 0, 32'h0, 0, 0, 32'h0,  32'h0, 0, 0));
    tbl.push_back(mk(32'h0, 0, 1, 0, 32'h0,  1, 0, 32'h0, 1, 1, 32'h13, 32'h0, 0, 1));
    // Memory stalls the request three cycles, then answers four cycles later.
    tbl.push_back(mk(32'h4, 0, 0, 0, 32'h0,  0, 0, 32'h0, 0, 0, 32'h0,  32'h0, 0, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(32'h4, 0, 0, 0, 32'h0, 0, 1, 32'h4, 0, 0, 32'h0, 32'h0, 0, 0));
    tbl.push_back(mk(32'h4, 0, 1, 0, 32'h0,  0, 1, 32'h4, 0, 0, 32'h0,  32'h0, 0, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(32'h4, 0, 0, 0, 32'h0, 0, 0, 32'h4, 0, 0, 32'h0, 32'h0, 0, 0));
    tbl.push_back(mk(32'h4, 0, 0, 1, 32'h0040_0093, 0, 0, 32'h4, 0, 0, 32'h0, 32'h0, 0, 0));
    // Decode back-pressure for five cycles.
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(32'h4, 0, 0, 0, 32'h0, 0, 0, 32'h4, 1, 1, 32'h0040_0093, 32'h4, 0, 0));
    tbl.push_back(mk(32'h4, 0, 0, 0, 32'h0,  1, 0, 32'h4, 1, 1, 32'h0040_0093, 32'h4, 0, 1));
    // Flush while waiting; the stale response must be swallowed.
    tbl.push_back(mk(32'h8,   0, 1, 0, 32'h0, 0, 0, 32'h4,   0, 0, 32'h0, 32'h0, 0, 0));
    tbl.push_back(mk(32'h8,   0, 1, 0, 32'h0, 0, 1, 32'h8,   0, 0, 32'h0, 32'h0, 0, 0));
    tbl.push_back(mk(32'h8,   1, 1, 0, 32'h0, 0, 0, 32'h8,   0, 0, 32'h0, 32'h0, 0, 0));
    tbl.push_back(mk(32'h100, 0, 1, 1, 32'hDEAD_BEEF, 0, 0, 32'h8, 0, 0, 32'h0, 32'h0, 0, 0));
    tbl.push_back(mk(32'h100, 0, 1, 0, 32'h0, 0, 0, 32'h8,   0, 0, 32'h0, 32'h0, 0, 0));
    tbl.push_back(mk(32'h100, 0, 1, 0, 32'h0, 0, 1, 32'h100, 0, 0, 32'h0, 32'h0, 0, 0));
    tbl.push_back(mk(32'h100, 0, 1, 1, 32'h1234_5678, 0, 0, 32'h100, 0, 0, 32'h0, 32'h0, 0, 0));
    tbl.push_back(mk(32'h100, 0, 1, 0, 32'h0, 1, 0, 32'h100, 1, 1, 32'h1234_5678, 32'h100, 0, 1));
    // Misaligned PC: fault word with no memory request, then flush beats accept.
    tbl.push_back(mk(32'h102, 0, 1, 0, 32'h0, 0, 0, 32'h100, 0, 0, 32'h0, 32'h0, 0, 0));
    tbl.push_back(mk(32'h102, 0, 1, 0, 32'h0, 0, 0, 32'h100, 1, 1, 32'h0, 32'h102, 1, 0));
    tbl.push_back(mk(32'h102, 1, 1, 0, 32'h0, 1, 0, 32'h100, 1, 1, 32'h0, 32'h102, 1, 0));
    tbl.push_back(mk(32'h200, 0, 1, 0, 32'h0, 0, 0, 32'h100, 0, 0, 32'h0, 32'h0, 0, 0));
    tbl.push_back(mk(32'h200, 0, 1, 0, 32'h0, 0, 1, 32'h200, 0, 0, 32'h0, 32'h0, 0, 0));

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < tbl.size(); i++)
      run_row(tbl[i], $sformatf("row%0d", i));

    // Now in WAIT for 0x200: asynchronous reset must clear outputs at once.
    idle_inputs();
    #2;
    rst = 1'b0;
    #1;
    check("async rst req_valid",  {31'd0, bus.imem_req_valid}, 32'd0);
    check("async rst req_addr",   bus.imem_req_addr, 32'h0);
    check("async rst inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("async rst inst_data",  bus.inst_data, 32'h0);
    check("async rst inst_pc",    bus.inst_pc, 32'h0);
    check("async rst inst_fault", {31'd0, bus.inst_fault}, 32'd0);
    check("async rst pc_en",      {31'd0, pc_en}, 32'd0);
    $display("async reset in WAIT: addr=%h ipc=%h flt=%0b", bus.imem_req_addr, bus.inst_pc, bus.inst_fault);
    @(posedge clk);
    #1;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hBADB_AD00;
    @(posedge clk);
    #1;
    bus.imem_rsp_valid = 1'b0;
    rst = 1'b1;
    run_row(mk(32'h40, 0, 1, 0, 32'h0, 1, 0, 32'h0,  0, 1, 32'h0, 32'h0, 0, 0), "post-rst idle");
    run_row(mk(32'h40, 0, 1, 0, 32'h0, 1, 1, 32'h40, 0, 0, 32'h0, 32'h0, 0, 0), "post-rst req");
    run_row(mk(32'h40, 0, 1, 1, 32'h0000_0113, 1, 0, 32'h40, 0, 0, 32'h0, 32'h0, 0, 0), "post-rst wait");
    run_row(mk(32'h40, 0, 1, 0, 32'h0, 1, 0, 32'h40, 1, 1, 32'h0000_0113, 32'h40, 0, 1), "post-rst full");

    // Randomized run: bench owns the PC register and a one-deep memory.
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    pc_model    = 32'h0;
    outstanding = 1'b0;
    out_addr    = 32'h0;
    cnt         = 0;
    delivered   = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      pc_in              = pc_model;
      bus.imem_req_ready = ($urandom_range(0, 3) != 0);
      bus.inst_ready     = ($urandom_range(0, 2) != 0);
      rsp_now = 1'b0;
      if (outstanding) begin
        cnt--;
        if (cnt == 0) rsp_now = 1'b1;
      end
      bus.imem_rsp_valid = rsp_now;
      bus.imem_rsp_data  = rsp_now ? memf(out_addr) : $urandom;
      // Redirects only arrive while a fetch is in progress.
      flush = (bus.imem_req_valid || outstanding || bus.inst_valid) && ($urandom_range(0, 11) == 0);
      tgt = {22'd0, 8'($urandom_range(0, 255)), 2'b00} + (($urandom_range(0, 5) == 0) ? 32'd2 : 32'd0);
      #4;
      accept = bus.inst_valid && bus.inst_ready && !flush;
      check("rand pc_en", {31'd0, pc_en}, {31'd0, accept});
      if (bus.imem_req_valid && !flush)
        check("rand req_addr", bus.imem_req_addr, pc_model);
      if (accept) begin
        exp_fault = (pc_model[1:0] != 2'b00);
        check("rand inst_pc",    bus.inst_pc, pc_model);
        check("rand inst_fault", {31'd0, bus.inst_fault}, {31'd0, exp_fault});
        check("rand inst_data",  bus.inst_data, exp_fault ? 32'h0 : memf(pc_model));
        delivered++;
        $display("rand cyc%0d: pc=%h data=%h fault=%0b", cyc, bus.inst_pc, bus.inst_data, bus.inst_fault);
      end
      if (rsp_now) outstanding = 1'b0;
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        check("rand single outstanding", {31'd0, outstanding}, 32'd0);
        outstanding = 1'b1;
        out_addr    = bus.imem_req_addr;
        cnt         = $urandom_range(1, 4);
      end
      if (flush)       pc_model = tgt;
      else if (accept) pc_model = (pc_model + 32'd4) & 32'hFFFF_FFFC;
      @(posedge clk);
      #1;
    end
    check("rand delivered>50", {31'd0, (delivered > 50)}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
